counter_sweep_ctrl: RTL and testbench
=====================================

// Module: counter_sweep_ctrl
// PURPOSE
//  Sequencer for one shared Up_Dn_Counter. Two requesters each ask for a sweep (START, END);
//  a round-robin arbiter grants one, the FSM loads START, then steps Up/Down until the counter equals END.
//  Sits between requesters and the counter, and is the only driver of IN/Load/Up/Down.
// PARAMETERS
//  WIDTH    5   counter/data width; must equal the counter width
//  TIMEOUT  40  max RUN cycles before a sweep is failed (>= 2**WIDTH+1)
// PORTS
//  CLK       in   1      clock, rising edge
//  RST       in   1      synchronous, active-high reset
//  REQ       in   2      per-requester sweep request; held until ACK
//  START0/1  in   WIDTH  sweep start value of requester 0/1; stable while REQ is high
//  END0/1    in   WIDTH  sweep end value of requester 0/1; stable while REQ is high
//  ABORT     in   1      cancel the active sweep
//  ACK       out  2      one-cycle completion pulse to the granted requester
//  ERR       out  1      valid with ACK: sweep aborted or timed out
//  BUSY      out  1      high in LOAD, RUN or DONE
//  GNT_ID    out  1      index of the granted requester; valid while BUSY
//  CNT_IN    out  WIDTH  to counter IN
//  CNT_LOAD  out  1      to counter Load
//  CNT_UP    out  1      to counter Up
//  CNT_DOWN  out  1      to counter Down
//  CNT_VAL   in   WIDTH  from counter Counter
//  CNT_HIGH  in   1      from counter High (value = max)
//  CNT_LOW   in   1      from counter Low (value = 0)
// BEHAVIOUR
//  Counter contract: Load has priority over Up/Down; Down has priority over Up; saturates at 0 and 2**WIDTH-1.
//  The controller never asserts Up and Down together.
//  Reset: state IDLE, RR priority to requester 0. ACK, ERR, BUSY, GNT_ID, CNT_* = 0.
//  Counter has no reset: with all CNT_* at 0 it holds its value.
//  FSM:
//   IDLE: if REQ != 0, grant (both high: requester with priority), latch START/END of winner -> LOAD.
//   LOAD (1 cycle): CNT_LOAD = 1, CNT_IN = start_q -> RUN.
//   RUN: combinational from CNT_VAL vs end_q:
//    - CNT_VAL == end_q: Up = Down = 0 -> DONE (ok).
//    - CNT_VAL <  end_q: Up = 1.  CNT_VAL > end_q: Down = 1.
//    - Watchdog counts RUN cycles; reaching TIMEOUT, or Up needed while CNT_HIGH, or Down needed while CNT_LOW,
//      -> DONE with err.
//   DONE (1 cycle): ACK[GNT_ID] = 1, ERR = err_q, all CNT_* = 0. Priority passes to the other requester -> IDLE.
//  ABORT in LOAD or RUN: CNT_* = 0 that cycle -> DONE with ERR = 1. ABORT is ignored in IDLE and DONE.
//  Latency: with REQ sampled in IDLE at cycle 0, ACK is high in cycle |END-START|+3.
//   RUN lasts |END-START|+1 cycles. START == END gives ACK in cycle 3.
//  Requester drops REQ at the edge where it samples ACK; REQ high again in IDLE is a new request.
//  REQ deasserted early (before ACK): the sweep still completes and ACK still pulses.
//  A REQ arriving while BUSY waits; no request is lost.
//  Unsigned compare, WIDTH bits; no wrap-around (the counter saturates).
//  Reset mid-sweep: IDLE next cycle and no ACK; the counter keeps its partial value.
// STRUCTURE
//  Package counter_sweep_pkg: state enum (IDLE, LOAD, RUN, DONE), WIDTH/TIMEOUT defaults.
//  Sub-module rr_arb2: 2-way round-robin arbiter (REQ, advance pulse -> GNT one-hot, GNT_ID).
//  Priority pointer updates only on DONE.
//  Top: FSM, start/end latches, watchdog counter, CNT_* decode.
// TESTING (with real Up_Dn_Counter instance)
//  1) REQ=01, START0=5, END0=9 -> counter 5,6,7,8,9; ACK=01 at cycle 7; ERR=0; no Up during LOAD.
//  2) REQ=10, START1=20, END1=3 -> counter steps down to 3; ACK=10 at cycle 20; CNT_UP never 1.
//  3) REQ=11 held, sweeps 0->2 each -> grants 0, 1, 0, 1 alternately; each ACK after 5 cycles.
//  4) START0=END0=31 -> ACK at cycle 3, ERR=0, High=1; START0=0, END0=31 -> ACK at cycle 34, ERR=0.
//  5) ABORT during RUN of 0->31 at counter=10 -> ACK with ERR=1 next cycle; counter holds 10.
//  6) RST mid-RUN -> all outputs 0 next cycle; no ACK; REQ=11 after reset is granted to 0 first.

Source files
------------

// File: rtl/counter_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_pkg
//  Description : Shared types and defaults for the counter sweep sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package counter_sweep_pkg;

    localparam int c_DEFAULT_WIDTH   = 5;
    localparam int c_DEFAULT_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sweep_state_t;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_ctrl_if
//  Description : Requester-side handshake bundle of the sweep sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_sweep_ctrl_if #(
    parameter int WIDTH = 5
);
    logic [1:0]       req;
    logic [WIDTH-1:0] start0;
    logic [WIDTH-1:0] start1;
    logic [WIDTH-1:0] end0;
    logic [WIDTH-1:0] end1;
    logic             abort;
    logic [1:0]       ack;
    logic             err;
    logic             busy;
    logic             gnt_id;

    modport master (
        output req, start0, start1, end0, end1, abort,
        input  ack, err, busy, gnt_id
    );

    modport slave (
        input  req, start0, start1, end0, end1, abort,
        output ack, err, busy, gnt_id
    );
endinterface
`default_nettype wire

// File: rtl/counter_sweep_ctrl_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin arbiter; priority moves only on advance.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import counter_sweep_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_req,
    input  wire logic       i_adv,
    input  wire logic       i_adv_id,
    output logic      [1:0] o_gnt,
    output logic            o_gnt_id
);

    // r_prio names the requester that wins when both are asking
    logic r_prio;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (i_adv) begin
            r_prio <= ~i_adv_id;
        end
    end

    always_comb begin
        o_gnt_id = 1'b0;
        o_gnt    = 2'b00;
        if (i_req == 2'b11) begin
            o_gnt_id = r_prio;
        end else begin
            o_gnt_id = i_req[1];
        end
        if (i_req != 2'b00) begin
            o_gnt = id_to_onehot(o_gnt_id);
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_sweep_ctrl
//  Description : Arbitrates two sweep requests and drives one up/down counter
//                from START to END, reporting completion or failure.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_sweep_ctrl
    import counter_sweep_pkg::*;
#(
    parameter int WIDTH   = c_DEFAULT_WIDTH,
    parameter int TIMEOUT = c_DEFAULT_TIMEOUT
) (
    input  wire logic             clk,
    input  wire logic             rst,
    counter_sweep_ctrl_if.slave   sweep_if,
    output logic      [WIDTH-1:0] o_cnt_in,
    output logic                  o_cnt_load,
    output logic                  o_cnt_up,
    output logic                  o_cnt_down,
    input  wire logic [WIDTH-1:0] i_cnt_val,
    input  wire logic             i_cnt_high,
    input  wire logic             i_cnt_low
);

    localparam int                c_WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

    sweep_state_t      r_state;
    sweep_state_t      w_state_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic [WIDTH-1:0]  r_start;
    logic [WIDTH-1:0]  r_end;
    logic              r_gnt_id;
    logic [c_WD_W-1:0] r_wdog;

    logic [1:0]        w_arb_gnt;
    logic              w_arb_id;
    logic              w_adv;
    logic              w_lt;
    logic              w_gt;
    logic              w_busy;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (sweep_if.req),
        .i_adv    (w_adv),
        .i_adv_id (r_gnt_id),
        .o_gnt    (w_arb_gnt),
        .o_gnt_id (w_arb_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Winner's operands are captured once so requesters may change them after ACK
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start  <= '0;
            r_end    <= '0;
            r_gnt_id <= 1'b0;
            r_wdog   <= '0;
        end else begin
            if (r_state == ST_IDLE && w_arb_gnt != 2'b00) begin
                r_gnt_id <= w_arb_id;
                r_start  <= w_arb_id ? sweep_if.start1 : sweep_if.start0;
                r_end    <= w_arb_id ? sweep_if.end1   : sweep_if.end0;
            end
            if (r_state == ST_LOAD) begin
                r_wdog <= '0;
            end else if (r_state == ST_RUN) begin
                r_wdog <= r_wdog + c_WD_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_adv       = 1'b0;
        o_cnt_in    = '0;
        o_cnt_load  = 1'b0;
        o_cnt_up    = 1'b0;
        o_cnt_down  = 1'b0;
        w_lt        = (i_cnt_val < r_end);
        w_gt        = (i_cnt_val > r_end);

        case (r_state)
            ST_IDLE: begin
                if (w_arb_gnt != 2'b00) begin
                    w_state_nxt = ST_LOAD;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (sweep_if.abort) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    o_cnt_load  = 1'b1;
                    o_cnt_in    = r_start;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sweep_if.abort) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end else if (!w_lt && !w_gt) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b0;
                end else if ((r_wdog == c_WD_LAST) ||
                             (w_lt && i_cnt_high) || (w_gt && i_cnt_low)) begin
                    // A saturated counter can never reach END; give up rather than spin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end else begin
                    o_cnt_up   = w_lt;
                    o_cnt_down = w_gt;
                end
            end
            ST_DONE: begin
                w_adv       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy          = (r_state != ST_IDLE);
    assign sweep_if.busy   = w_busy;
    assign sweep_if.gnt_id = w_busy & r_gnt_id;
    assign sweep_if.ack    = (r_state == ST_DONE) ? id_to_onehot(r_gnt_id) : 2'b00;
    assign sweep_if.err    = (r_state == ST_DONE) & r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_sweep_ctrl
//  Description : Directed self-checking bench with a saturating up/down counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] cnt_in;
    logic       cnt_load;
    logic       cnt_up;
    logic       cnt_down;
    logic [4:0] cnt_q = 5'd0;
    logic       cnt_high;
    logic       cnt_low;

    int n_tests = 0;
    int n_fail  = 0;
    int up_cnt;
    int down_cnt;
    int both_seen;
    int load_step_seen;
    int cyc;

    counter_sweep_ctrl_if #(.WIDTH(5)) sweep_if ();

    counter_sweep_ctrl #(.WIDTH(5), .TIMEOUT(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .sweep_if   (sweep_if),
        .o_cnt_in   (cnt_in),
        .o_cnt_load (cnt_load),
        .o_cnt_up   (cnt_up),
        .o_cnt_down (cnt_down),
        .i_cnt_val  (cnt_q),
        .i_cnt_high (cnt_high),
        .i_cnt_low  (cnt_low)
    );

    // Up_Dn_Counter: Load > Down > Up, saturating, no reset
    always @(posedge clk) begin
        if (cnt_load)                        cnt_q <= cnt_in;
        else if (cnt_down && cnt_q != 5'd0)  cnt_q <= cnt_q - 5'd1;
        else if (!cnt_down && cnt_up && cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
    end
    assign cnt_high = (cnt_q == 5'd31);
    assign cnt_low  = (cnt_q == 5'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int cycles);
        cycles         = 0;
        up_cnt         = 0;
        down_cnt       = 0;
        both_seen      = 0;
        load_step_seen = 0;
        while (sweep_if.ack == 2'b00 && cycles < 200) begin
            tick();
            cycles++;
            up_cnt   += int'(cnt_up);
            down_cnt += int'(cnt_down);
            if (cnt_up && cnt_down)               both_seen = 1;
            if (cnt_load && (cnt_up || cnt_down)) load_step_seen = 1;
        end
    endtask

    task automatic do_sweep(input string tag, input logic id, input logic [4:0] s,
                            input logic [4:0] e, input int exp_lat);
        if (id) begin
            sweep_if.start1 = s;
            sweep_if.end1   = e;
            sweep_if.req    = 2'b10;
        end else begin
            sweep_if.start0 = s;
            sweep_if.end0   = e;
            sweep_if.req    = 2'b01;
        end
        wait_ack(cyc);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_ack"}, sweep_if.ack, id ? 2'b10 : 2'b01);
        check({tag, "_err"}, sweep_if.err, 1'b0);
        check({tag, "_gnt_id"}, sweep_if.gnt_id, id);
        check({tag, "_final_cnt"}, cnt_q, e);
        check({tag, "_up_and_down"}, both_seen, 0);
        check({tag, "_step_in_load"}, load_step_seen, 0);
        sweep_if.req = 2'b00;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        sweep_if.req    = 2'b00;
        sweep_if.abort  = 1'b0;
        sweep_if.start0 = 5'd0;
        sweep_if.start1 = 5'd0;
        sweep_if.end0   = 5'd0;
        sweep_if.end1   = 5'd0;
        tick(); tick(); tick();

        check("rst_ack",    sweep_if.ack, 2'b00);
        check("rst_err",    sweep_if.err, 1'b0);
        check("rst_busy",   sweep_if.busy, 1'b0);
        check("rst_gnt_id", sweep_if.gnt_id, 1'b0);
        check("rst_cnt_in", cnt_in, 5'd0);
        check("rst_load",   cnt_load, 1'b0);
        check("rst_up",     cnt_up, 1'b0);
        check("rst_down",   cnt_down, 1'b0);
        rst = 1'b0;
        tick();

        // 1) upward sweep 5 -> 9
        do_sweep("t1", 1'b0, 5'd5, 5'd9, 7);
        check("t1_up_pulses",   up_cnt, 4);
        check("t1_down_pulses", down_cnt, 0);

        // 2) downward sweep 20 -> 3
        do_sweep("t2", 1'b1, 5'd20, 5'd3, 20);
        check("t2_up_pulses",   up_cnt, 0);
        check("t2_down_pulses", down_cnt, 17);

        // 3) both requesting continuously: strict alternation starting at 0
        sweep_if.start0 = 5'd0; sweep_if.end0 = 5'd2;
        sweep_if.start1 = 5'd0; sweep_if.end1 = 5'd2;
        sweep_if.req    = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(cyc);
            check("t3_latency", cyc, 5);
            check("t3_ack", sweep_if.ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("t3_err", sweep_if.err, 1'b0);
            check("t3_cnt", cnt_q, 5'd2);
            tick();
        end
        sweep_if.req = 2'b00;
        check("t3_idle_after", sweep_if.busy, 1'b0);
        tick();

        // 4) boundaries: START == END at max, then full-range sweep
        do_sweep("t4a", 1'b0, 5'd31, 5'd31, 3);
        check("t4a_high", cnt_high, 1'b1);
        do_sweep("t4b", 1'b0, 5'd0, 5'd31, 34);
        check("t4b_up_pulses", up_cnt, 31);
        check("t4b_high", cnt_high, 1'b1);

        // 5) abort while the counter shows 10
        sweep_if.start0 = 5'd0;
        sweep_if.end0   = 5'd31;
        sweep_if.req    = 2'b01;
        cyc = 0;
        while (!(sweep_if.busy && !cnt_load && cnt_q == 5'd10) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t5_reach_10", cyc, 12);
        sweep_if.abort = 1'b1;
        #1;
        check("t5_abort_up",   cnt_up, 1'b0);
        check("t5_abort_down", cnt_down, 1'b0);
        tick();
        sweep_if.abort = 1'b0;
        check("t5_ack", sweep_if.ack, 2'b01);
        check("t5_err", sweep_if.err, 1'b1);
        check("t5_cnt_hold", cnt_q, 5'd10);
        sweep_if.req = 2'b00;
        tick();
        check("t5_idle", sweep_if.busy, 1'b0);

        // 6) reset in RUN; priority currently favours requester 1
        sweep_if.start0 = 5'd0;
        sweep_if.end0   = 5'd20;
        sweep_if.req    = 2'b01;
        cyc = 0;
        while (!(sweep_if.busy && !cnt_load && cnt_q == 5'd5) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t6_reach_5", cyc, 7);
        rst          = 1'b1;
        sweep_if.req = 2'b00;
        tick();
        check("t6_busy",   sweep_if.busy, 1'b0);
        check("t6_ack",    sweep_if.ack, 2'b00);
        check("t6_err",    sweep_if.err, 1'b0);
        check("t6_gnt_id", sweep_if.gnt_id, 1'b0);
        check("t6_cnt_in", cnt_in, 5'd0);
        check("t6_ctl",    {cnt_load, cnt_up, cnt_down}, 3'b000);
        check("t6_partial_cnt", cnt_q, 5'd6);
        rst = 1'b0;
        both_seen = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (sweep_if.ack != 2'b00) both_seen = 1;
        end
        check("t6_no_ack", both_seen, 0);
        check("t6_cnt_kept", cnt_q, 5'd6);

        sweep_if.start0 = 5'd7;  sweep_if.end0 = 5'd7;
        sweep_if.start1 = 5'd12; sweep_if.end1 = 5'd12;
        sweep_if.req    = 2'b11;
        tick();
        check("t6_regrant_busy", sweep_if.busy, 1'b1);
        check("t6_regrant_id",   sweep_if.gnt_id, 1'b0);
        wait_ack(cyc);
        check("t6_regrant_lat", cyc, 2);
        check("t6_regrant_ack", sweep_if.ack, 2'b01);
        check("t6_regrant_cnt", cnt_q, 5'd7);
        sweep_if.req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
